pipe_ctrl: RTL

Central pipeline sequencer for the five-stage core. It merges the decode-stage RAW stall request, instruction- and data-memory wait handshakes, EX-stage control-flow redirects and WB-stage halt into per-stage register enables and flushes. The PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers take their `en`/`flush` only from this block. A 4-state FSM, a pending-redirect flag and a saturating stall-cycle counter make up its sequential state.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_ctrl_sat_counter.sv | 25 ++
 rtl/pipe_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the pipeline sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DWAIT = 2'b01,
    IWAIT = 2'b10,
    HALT  = 2'b11
  } state_e;

  localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stall, wait, redirect and halt requests into
// per-stage register enables and flushes for the five-stage core.
//
// state | meaning
// RUN   | normal flow
// DWAIT | stalled on a data-memory access
// IWAIT | bubbling decode while a fetch is outstanding
// HALT  | core stopped until reset
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_stall,
  input  logic             redirect,
  input  logic             imem_busy,
  input  logic             imem_done,
  input  logic             dmem_req,
  input  logic             dmem_done,
  input  logic             halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  logic   pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic   ifid_flush_c, idex_flush_c;
  logic   dwait, iwait;

  assign dwait = dmem_req & ~dmem_done;
  assign iwait = imem_busy & ~imem_done;

  always_comb begin
    state_d      = RUN;
    pend_d       = pend_q;
    pc_en_c      = 1'b1;
    ifid_en_c    = 1'b1;
    idex_en_c    = 1'b1;
    exmem_en_c   = 1'b1;
    memwb_en_c   = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    if (state_q == HALT) begin
      state_d = HALT;
      {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
    end else begin
      if (dwait) begin
        state_d = DWAIT;
        {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
      end else if (halt) begin
        state_d = HALT;
        {pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c} = '0;
      end else if (redirect) begin
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
        if (iwait) pend_d = 1'b1;
      end else if (iwait) begin
        state_d      = IWAIT;
        pc_en_c      = 1'b0;
        ifid_flush_c = 1'b1;
      end else if (hz_stall) begin
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        idex_flush_c = 1'b1;
      end
      // The stale fetch word is only gone once IF/ID actually loads the NOP.
      if (pend_q && imem_done) begin
        ifid_flush_c = 1'b1;
        if (ifid_en_c) pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  assign pc_en      = rst & pc_en_c;
  assign ifid_en    = rst & ifid_en_c;
  assign idex_en    = rst & idex_en_c;
  assign exmem_en   = rst & exmem_en_c;
  assign memwb_en   = rst & memwb_en_c;
  assign ifid_flush = rst & ifid_flush_c;
  assign idex_flush = rst & idex_flush_c;
  assign halted     = (state_q == HALT);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (~pc_en_c && (state_q != HALT)),
    .cnt (stall_cnt)
  );

endmodule
